// File: rtl/soft_rst_pkg.sv
// Shared types and constants for the soft-reset request controller.
// Also holds the pad-encoding helper that maps a reset kind onto cpu_pad_soft_rst.
package soft_rst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSERT   = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    typedef enum logic {
        KIND_CORE = 1'b0,
        KIND_SYS  = 1'b1
    } kind_t;

    localparam int CAUSE_POR    = 0;
    localparam int CAUSE_SWCORE = 1;
    localparam int CAUSE_SWSYS  = 2;
    localparam int CAUSE_WDT    = 3;
    localparam int CAUSE_DBG    = 4;
    localparam int CAUSE_W      = 5;

    localparam logic [CAUSE_W-1:0] CAUSE_RESET_VAL = 5'b00001;
    localparam logic [15:0]        DEFAULT_SW_KEY  = 16'hA55A;

    // Counter must hold max(HOLD,COOL)-1; never narrower than one bit.
    function automatic int cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

    function automatic logic [1:0] kind_to_pad(input kind_t k);
        return (k == KIND_SYS) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rst_sync2.sv
// Two-flop synchronizer with asynchronous assert (clear) for reset-status signals.
module rst_sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/soft_rst_ctrl.sv
// Arbitrates watchdog/software/debug reset requests into a fixed-width pad pulse,
// enforces a cooldown, and keeps a sticky reset-cause register.
module soft_rst_ctrl
    import soft_rst_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned COOL_CYCLES = 32,
    parameter logic [15:0] SW_KEY      = DEFAULT_SW_KEY
) (
    input  logic               clk,
    input  logic               mcu_rst_signal,
    input  logic               sw_req_valid,
    output logic               sw_req_ready,
    input  logic               sw_req_type,
    input  logic [15:0]        sw_req_key,
    output logic               sw_key_err,
    input  logic               wdt_timeout,
    input  logic               had_core_req,
    input  logic               sys_resetn,
    output logic [1:0]         cpu_pad_soft_rst,
    output logic               busy,
    output logic [CAUSE_W-1:0] rst_cause,
    input  logic               cause_clr
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, COOL_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOL_CYCLES - 1);

    state_t               r_state, w_state_next;
    kind_t                r_kind, w_kind_next;
    logic [CNT_W-1:0]     r_cnt, w_cnt_next;
    logic [1:0]           r_pad;
    logic                 r_busy;
    logic                 r_key_err;
    logic [CAUSE_W-1:0]   r_cause;
    logic [CAUSE_W-1:0]   w_cause_set;
    logic                 w_key_ok;
    logic                 w_key_err;
    logic                 w_accept;
    logic                 w_sys_ok;

    rst_sync2 u_sys_sync (
        .i_clk   (clk),
        .i_rst_n (mcu_rst_signal),
        .i_d     (sys_resetn),
        .o_q     (w_sys_ok)
    );

    assign w_key_ok = (sw_req_key == SW_KEY);

    always_comb begin
        w_state_next = r_state;
        w_kind_next  = r_kind;
        w_cnt_next   = r_cnt;
        w_cause_set  = '0;
        w_key_err    = 1'b0;
        w_accept     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                // Handshake completes regardless of key; a bad key only flags an error.
                w_key_err = sw_req_valid && !w_key_ok;
                if (wdt_timeout) begin
                    w_accept = 1'b1;
                    w_kind_next = KIND_SYS;
                    w_cause_set[CAUSE_WDT] = 1'b1;
                end else if (sw_req_valid && w_key_ok && sw_req_type) begin
                    w_accept = 1'b1;
                    w_kind_next = KIND_SYS;
                    w_cause_set[CAUSE_SWSYS] = 1'b1;
                end else if (had_core_req) begin
                    w_accept = 1'b1;
                    w_kind_next = KIND_CORE;
                    w_cause_set[CAUSE_DBG] = 1'b1;
                end else if (sw_req_valid && w_key_ok) begin
                    w_accept = 1'b1;
                    w_kind_next = KIND_CORE;
                    w_cause_set[CAUSE_SWCORE] = 1'b1;
                end
                if (w_accept) begin
                    w_state_next = ST_ASSERT;
                    w_cnt_next   = HOLD_LOAD;
                end
            end
            ST_ASSERT: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_COOLDOWN;
                    w_cnt_next   = COOL_LOAD;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_COOLDOWN: begin
                // Counter parks at zero while a system reset is still in progress.
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end else if (r_kind == KIND_CORE || w_sys_ok) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge mcu_rst_signal) begin
        if (!mcu_rst_signal) begin
            r_state   <= ST_IDLE;
            r_kind    <= KIND_CORE;
            r_cnt     <= '0;
            r_pad     <= 2'b00;
            r_busy    <= 1'b0;
            r_key_err <= 1'b0;
            r_cause   <= CAUSE_RESET_VAL;
        end else begin
            r_state   <= w_state_next;
            r_kind    <= w_kind_next;
            r_cnt     <= w_cnt_next;
            r_pad     <= (w_state_next == ST_ASSERT) ? kind_to_pad(w_kind_next) : 2'b00;
            r_busy    <= (w_state_next != ST_IDLE);
            r_key_err <= w_key_err;
            r_cause   <= (cause_clr ? '0 : r_cause) | w_cause_set;
        end
    end

    assign sw_req_ready     = mcu_rst_signal && (r_state == ST_IDLE);
    assign cpu_pad_soft_rst = r_pad;
    assign busy             = r_busy;
    assign sw_key_err       = r_key_err;
    assign rst_cause        = r_cause;

endmodule

// File: tb/tb_soft_rst_ctrl.sv
// Self-checking bench for soft_rst_ctrl: directed scenarios plus a randomized run
// against a timestamp-based reference model.
module tb_soft_rst_ctrl;

    localparam int H = 16;
    localparam int C = 32;
    localparam logic [15:0] KEY = 16'hA55A;

    logic        clk = 1'b0;
    logic        mcu_rst_signal = 1'b0;
    logic        sw_req_valid = 1'b0;
    logic        sw_req_ready;
    logic        sw_req_type = 1'b0;
    logic [15:0] sw_req_key = 16'h0;
    logic        sw_key_err;
    logic        wdt_timeout = 1'b0;
    logic        had_core_req = 1'b0;
    logic        sys_resetn = 1'b1;
    logic [1:0]  cpu_pad_soft_rst;
    logic        busy;
    logic [4:0]  rst_cause;
    logic        cause_clr = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    soft_rst_ctrl #(.HOLD_CYCLES(H), .COOL_CYCLES(C), .SW_KEY(KEY)) dut (
        .clk              (clk),
        .mcu_rst_signal   (mcu_rst_signal),
        .sw_req_valid     (sw_req_valid),
        .sw_req_ready     (sw_req_ready),
        .sw_req_type      (sw_req_type),
        .sw_req_key       (sw_req_key),
        .sw_key_err       (sw_key_err),
        .wdt_timeout      (wdt_timeout),
        .had_core_req     (had_core_req),
        .sys_resetn       (sys_resetn),
        .cpu_pad_soft_rst (cpu_pad_soft_rst),
        .busy             (busy),
        .rst_cause        (rst_cause),
        .cause_clr        (cause_clr)
    );

    task automatic idle_inputs();
        sw_req_valid = 1'b0;
        sw_req_type  = 1'b0;
        sw_req_key   = 16'h0;
        wdt_timeout  = 1'b0;
        had_core_req = 1'b0;
        cause_clr    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        mcu_rst_signal = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        mcu_rst_signal = 1'b1;
    endtask

    task automatic test_reset();
        mcu_rst_signal = 1'b0;
        sys_resetn = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        n_checks++; if (sw_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_rst: got %b expected 0", sw_req_ready); end
        n_checks++; if (cpu_pad_soft_rst !== 2'b00) begin n_fail++; $display("FAIL reset_pad: got %b expected 00", cpu_pad_soft_rst); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (sw_key_err !== 1'b0) begin n_fail++; $display("FAIL reset_key_err: got %b expected 0", sw_key_err); end
        mcu_rst_signal = 1'b1;
        @(negedge clk);
        n_checks++; if (rst_cause !== 5'b00001) begin n_fail++; $display("FAIL por_cause: got %b expected 00001", rst_cause); end
        n_checks++; if (sw_req_ready !== 1'b1) begin n_fail++; $display("FAIL por_ready: got %b expected 1", sw_req_ready); end
        n_checks++; if (cpu_pad_soft_rst !== 2'b00) begin n_fail++; $display("FAIL por_pad: got %b expected 00", cpu_pad_soft_rst); end
        $display("test_reset: por cause=%b ready=%b", rst_cause, sw_req_ready);
    endtask

    task automatic test_sw_core();
        logic [1:0] pad_hist [0:63];
        logic       busy_hist [0:63];
        logic       rdy_hist [0:63];
        int pad_cnt = 0;
        int busy_cnt = 0;
        do_reset();
        sw_req_valid = 1'b1; sw_req_key = KEY; sw_req_type = 1'b0;
        @(negedge clk);
        idle_inputs();
        n_checks++; if (rst_cause !== 5'b00011) begin n_fail++; $display("FAIL swcore_cause: got %b expected 00011", rst_cause); end
        for (int i = 0; i < 64; i++) begin
            pad_hist[i] = cpu_pad_soft_rst;
            busy_hist[i] = busy;
            rdy_hist[i] = sw_req_ready;
            if (cpu_pad_soft_rst == 2'b01) pad_cnt++;
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        n_checks++; if (pad_hist[0] !== 2'b01) begin n_fail++; $display("FAIL swcore_pad_first: got %b expected 01", pad_hist[0]); end
        n_checks++; if (pad_hist[H-1] !== 2'b01) begin n_fail++; $display("FAIL swcore_pad_last: got %b expected 01", pad_hist[H-1]); end
        n_checks++; if (pad_hist[H] !== 2'b00) begin n_fail++; $display("FAIL swcore_pad_after: got %b expected 00", pad_hist[H]); end
        n_checks++; if (pad_cnt != H) begin n_fail++; $display("FAIL swcore_pad_len: got %0d expected %0d", pad_cnt, H); end
        n_checks++; if (busy_hist[H+C-1] !== 1'b1) begin n_fail++; $display("FAIL swcore_busy_last: got %b expected 1", busy_hist[H+C-1]); end
        n_checks++; if (busy_hist[H+C] !== 1'b0) begin n_fail++; $display("FAIL swcore_busy_after: got %b expected 0", busy_hist[H+C]); end
        n_checks++; if (busy_cnt != H + C) begin n_fail++; $display("FAIL swcore_busy_len: got %0d expected %0d", busy_cnt, H + C); end
        n_checks++; if (rdy_hist[H+C-1] !== 1'b0) begin n_fail++; $display("FAIL swcore_ready_cool: got %b expected 0", rdy_hist[H+C-1]); end
        n_checks++; if (rdy_hist[H+C] !== 1'b1) begin n_fail++; $display("FAIL swcore_ready_idle: got %b expected 1", rdy_hist[H+C]); end
        $display("test_sw_core: pad_len=%0d busy_len=%0d cause=%b", pad_cnt, busy_cnt, rst_cause);
    endtask

    task automatic test_bad_key();
        sw_req_valid = 1'b1; sw_req_key = 16'h1234; sw_req_type = 1'b0;
        n_checks++; if (sw_req_ready !== 1'b1) begin n_fail++; $display("FAIL badkey_ready: got %b expected 1", sw_req_ready); end
        @(negedge clk);
        idle_inputs();
        n_checks++; if (sw_key_err !== 1'b1) begin n_fail++; $display("FAIL badkey_err: got %b expected 1", sw_key_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL badkey_busy: got %b expected 0", busy); end
        n_checks++; if (cpu_pad_soft_rst !== 2'b00) begin n_fail++; $display("FAIL badkey_pad: got %b expected 00", cpu_pad_soft_rst); end
        n_checks++; if (rst_cause !== 5'b00011) begin n_fail++; $display("FAIL badkey_cause: got %b expected 00011", rst_cause); end
        @(negedge clk);
        n_checks++; if (sw_key_err !== 1'b0) begin n_fail++; $display("FAIL badkey_err_pulse: got %b expected 0", sw_key_err); end
        $display("test_bad_key: no reset issued, cause=%b", rst_cause);
    endtask

    task automatic test_simultaneous();
        do_reset();
        wdt_timeout = 1'b1; had_core_req = 1'b1;
        sw_req_valid = 1'b1; sw_req_key = KEY; sw_req_type = 1'b0;
        @(negedge clk);
        wdt_timeout = 1'b0; sw_req_valid = 1'b0; sw_req_key = 16'h0;
        n_checks++; if (cpu_pad_soft_rst !== 2'b10) begin n_fail++; $display("FAIL simul_pad: got %b expected 10", cpu_pad_soft_rst); end
        n_checks++; if (rst_cause !== 5'b01001) begin n_fail++; $display("FAIL simul_cause: got %b expected 01001", rst_cause); end
        n_checks++; if (sw_key_err !== 1'b0) begin n_fail++; $display("FAIL simul_key_err: got %b expected 0", sw_key_err); end
        for (int i = 1; i <= H + C + 1; i++) begin
            @(negedge clk);
            if (i == H + C) begin
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL simul_idle_gap: got %b expected 0", busy); end
            end
        end
        n_checks++; if (cpu_pad_soft_rst !== 2'b01) begin n_fail++; $display("FAIL simul_dbg_pad: got %b expected 01", cpu_pad_soft_rst); end
        n_checks++; if (rst_cause !== 5'b11001) begin n_fail++; $display("FAIL simul_dbg_cause: got %b expected 11001", rst_cause); end
        had_core_req = 1'b0;
        repeat (H + C + 2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL simul_final_idle: got %b expected 0", busy); end
        $display("test_simultaneous: wdt then dbg, cause=%b", rst_cause);
    endtask

    task automatic test_sys_gating();
        logic [1:0] pad_hist [0:119];
        logic       busy_hist [0:119];
        do_reset();
        sys_resetn = 1'b0;
        sw_req_valid = 1'b1; sw_req_key = KEY; sw_req_type = 1'b1;
        @(negedge clk);
        idle_inputs();
        n_checks++; if (rst_cause !== 5'b00101) begin n_fail++; $display("FAIL sys_cause: got %b expected 00101", rst_cause); end
        for (int j = 0; j < 120; j++) begin
            pad_hist[j] = cpu_pad_soft_rst;
            busy_hist[j] = busy;
            if (j == 100) sys_resetn = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (pad_hist[0] !== 2'b10) begin n_fail++; $display("FAIL sys_pad_first: got %b expected 10", pad_hist[0]); end
        n_checks++; if (pad_hist[H] !== 2'b00) begin n_fail++; $display("FAIL sys_pad_after: got %b expected 00", pad_hist[H]); end
        n_checks++; if (busy_hist[60] !== 1'b1) begin n_fail++; $display("FAIL sys_busy_gated: got %b expected 1", busy_hist[60]); end
        n_checks++; if (busy_hist[102] !== 1'b1) begin n_fail++; $display("FAIL sys_busy_sync: got %b expected 1", busy_hist[102]); end
        n_checks++; if (busy_hist[103] !== 1'b0) begin n_fail++; $display("FAIL sys_busy_release: got %b expected 0", busy_hist[103]); end
        $display("test_sys_gating: busy released 3 cycles after sys_resetn rise");
    endtask

    task automatic test_mid_reset();
        do_reset();
        sw_req_valid = 1'b1; sw_req_key = KEY; sw_req_type = 1'b0; cause_clr = 1'b1;
        @(negedge clk);
        idle_inputs();
        n_checks++; if (rst_cause !== 5'b00010) begin n_fail++; $display("FAIL setclr_cause: got %b expected 00010", rst_cause); end
        repeat (4) @(negedge clk);
        n_checks++; if (cpu_pad_soft_rst !== 2'b01) begin n_fail++; $display("FAIL mid_pad_pre: got %b expected 01", cpu_pad_soft_rst); end
        @(posedge clk);
        #2 mcu_rst_signal = 1'b0;
        #1;
        n_checks++; if (cpu_pad_soft_rst !== 2'b00) begin n_fail++; $display("FAIL mid_pad: got %b expected 00", cpu_pad_soft_rst); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", busy); end
        n_checks++; if (rst_cause !== 5'b00001) begin n_fail++; $display("FAIL mid_cause: got %b expected 00001", rst_cause); end
        n_checks++; if (sw_req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b expected 0", sw_req_ready); end
        @(negedge clk);
        mcu_rst_signal = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_after_busy: got %b expected 0", busy); end
        n_checks++; if (sw_req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_after_ready: got %b expected 1", sw_req_ready); end
        $display("test_mid_reset: outputs dropped, cause=%b", rst_cause);
    endtask

    task automatic test_random(input int n);
        int   last_acc = -1000;
        bit   m_sys = 1'b0;
        logic [4:0] m_cause = 5'b00001;
        logic [4:0] set;
        logic [1:0] e_pad;
        logic e_busy, e_kerr;
        bit   v, t, w, d, clr, idle_before, acc, key_ok;
        logic [15:0] key;
        do_reset();
        sys_resetn = 1'b1;
        for (int k = 0; k < n; k++) begin
            v   = ($urandom_range(0, 3) == 0);
            t   = 1'($urandom_range(0, 1));
            key = ($urandom_range(0, 3) != 0) ? KEY : 16'($urandom);
            w   = ($urandom_range(0, 15) == 0);
            d   = ($urandom_range(0, 11) == 0);
            clr = ($urandom_range(0, 19) == 0);
            sw_req_valid = v; sw_req_type = t; sw_req_key = key;
            wdt_timeout = w; had_core_req = d; cause_clr = clr;
            @(posedge clk);
            key_ok = (key == KEY);
            idle_before = (k - last_acc) > (H + C);
            e_kerr = idle_before && v && !key_ok;
            set = 5'b0;
            acc = 1'b0;
            if (idle_before) begin
                if (w) begin acc = 1'b1; m_sys = 1'b1; set[3] = 1'b1; end
                else if (v && key_ok && t) begin acc = 1'b1; m_sys = 1'b1; set[2] = 1'b1; end
                else if (d) begin acc = 1'b1; m_sys = 1'b0; set[4] = 1'b1; end
                else if (v && key_ok) begin acc = 1'b1; m_sys = 1'b0; set[1] = 1'b1; end
                if (acc) last_acc = k;
            end
            m_cause = (clr ? 5'b0 : m_cause) | set;
            e_busy = (k - last_acc) < (H + C);
            e_pad = ((k - last_acc) < H) ? (m_sys ? 2'b10 : 2'b01) : 2'b00;
            @(negedge clk);
            if (acc) $display("rand: cycle %0d accept kind=%s cause=%b", k, m_sys ? "sys" : "core", m_cause);
            n_checks++; if (cpu_pad_soft_rst !== e_pad) begin n_fail++; $display("FAIL rand_pad@%0d: got %b expected %b", k, cpu_pad_soft_rst, e_pad); end
            n_checks++; if (busy !== e_busy) begin n_fail++; $display("FAIL rand_busy@%0d: got %b expected %b", k, busy, e_busy); end
            n_checks++; if (sw_req_ready !== !e_busy) begin n_fail++; $display("FAIL rand_ready@%0d: got %b expected %b", k, sw_req_ready, !e_busy); end
            n_checks++; if (sw_key_err !== e_kerr) begin n_fail++; $display("FAIL rand_key_err@%0d: got %b expected %b", k, sw_key_err, e_kerr); end
            n_checks++; if (rst_cause !== m_cause) begin n_fail++; $display("FAIL rand_cause@%0d: got %b expected %b", k, rst_cause, m_cause); end
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sw_core();
        test_bad_key();
        test_simultaneous();
        test_sys_gating();
        test_mid_reset();
        test_random(2000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/soft_rst_ctrl.md
# soft_rst_ctrl

Soft-reset request controller feeding `cpu_pad_soft_rst[1:0]` into the MCU reset generator. It arbitrates software, watchdog and debug reset requests and drives a fixed-width reset request pulse. It then enforces a cooldown so back-to-back requests cannot chatter the reset tree, and keeps a sticky reset-cause register. It is reset only by power-on/external reset, so cause bits survive every soft reset it issues.

## Interface
Parameters:
- `HOLD_CYCLES`, 16: cycles `cpu_pad_soft_rst` stays asserted per request (≥1).
- `COOL_CYCLES`, 32: minimum cycles after deassertion before a new request is accepted (≥1).
- `SW_KEY`, 16'hA55A: unlock key required on software requests.

Ports:
- `clk`  in  1  controller clock.
- `mcu_rst_signal`  in  1  reset: asynchronous, active-low; clock clk.
- `sw_req_valid`  in  1  software reset request valid.
- `sw_req_ready`  out  1  controller can accept a software request.
- `sw_req_type`  in  1  0 = core reset, 1 = system reset.
- `sw_req_key`  in  16  must equal `SW_KEY`.
- `sw_key_err`  out  1  one-cycle pulse on an accepted request with a bad key.
- `wdt_timeout`  in  1  watchdog timeout, level, clk-synchronous; requests a system reset.
- `had_core_req`  in  1  debug core-reset request, level, clk-synchronous.
- `sys_resetn`  in  1  system reset status from the MCU reset generator, async to clk.
- `cpu_pad_soft_rst`  out  2  bit0 = core reset request, bit1 = system reset request, active-high.
- `busy`  out  1  high in any state other than IDLE.
- `rst_cause`  out  5  sticky: [0] POR, [1] SW core, [2] SW sys, [3] WDT, [4] DBG core.
- `cause_clr`  in  1  clears `rst_cause` (one-cycle pulse).

## Operation
- FSM states: IDLE, ASSERT, COOLDOWN.
- **IDLE**
  - `sw_req_ready`=1.
  - Each cycle, evaluate candidates by fixed priority: WDT > SW sys > DBG core > SW core.
  - A SW candidate exists only when `sw_req_valid` is high and the key matches.
  - With no candidate, the state stays IDLE.
- **Accept**
  - Load the winner's type into `kind` (core/sys).
  - Set the winner's cause bit.
  - Go to ASSERT with `cnt`=HOLD_CYCLES-1.
- **Key mismatch**
  - The handshake still completes (`sw_req_ready` is high) and `sw_key_err` pulses.
  - No reset is issued and no cause bit is set.
- **Software request consumption**
  - A software request is consumed whenever `sw_req_valid & sw_req_ready`, even if a higher-priority source wins the same cycle.
  - In that case the software request is dropped with no error.
- **ASSERT**
  - `cpu_pad_soft_rst[0]`=1 when `kind`=core; `cpu_pad_soft_rst[1]`=1 when `kind`=sys. Never both.
  - Decrement `cnt`. At 0, go to COOLDOWN with `cnt`=COOL_CYCLES-1.
- **COOLDOWN**
  - Outputs are 0 and requests are ignored. `sw_req_ready`=0.
  - Decrement `cnt`.
  - Exit to IDLE when `cnt`=0, and additionally for `kind`=sys, when synchronized `sys_resetn`=1.
- **Level requests.** `wdt_timeout` and `had_core_req` are not latched. A source still high on return to IDLE is accepted again.
- **Cause register**
  - Set bits take priority over `cause_clr` in the same cycle.
  - `cause_clr` clears all bits, including POR.
- **Counter width:** `$clog2(max(HOLD_CYCLES,COOL_CYCLES))`, at least 1 bit.

## Timing
- **Reset values** (`mcu_rst_signal`=0, asynchronous):
  - state IDLE, `cpu_pad_soft_rst`=2'b00, `busy`=0, `sw_key_err`=0.
  - `rst_cause`=5'b00001, `sw_req_ready`=0 while in reset.
- **Reset mid-operation:** outputs drop immediately to reset values. The pending request is lost.
- **Registered outputs:** `cpu_pad_soft_rst` and `busy` are registered.
  - Accept happens at edge N.
  - `cpu_pad_soft_rst` is high from N+1 for exactly HOLD_CYCLES cycles.
- **Cooldown length:** `busy` stays high for HOLD_CYCLES+COOL_CYCLES cycles minimum.
- **Earliest re-accept:** edge N+HOLD_CYCLES+COOL_CYCLES+1 (core case).
- **`sw_req_ready`:** combinational from state (=IDLE).
- **`sw_key_err`:** registered, high at N+1.
- **`rst_cause`:** updates at N+1.
- **`sys_resetn`:** passed through a 2-flop synchronizer, reset to 0. COOLDOWN latency for sys requests therefore includes 2 extra cycles after `sys_resetn` rises.

## Structure
- **`soft_rst_pkg`:** state enum, `kind` encoding, cause bit index constants (CAUSE_POR=0 … CAUSE_DBG=4), default key.
- **`rst_sync2`:** one sub-module, a 2-flop async-assert synchronizer for `sys_resetn`, reused elsewhere in the reset domain.

## Test plan
- **Power-on:** release `mcu_rst_signal` → `rst_cause`=5'b00001, outputs 0, `sw_req_ready`=1.
- **SW core:** SW core request, key A55A, HOLD=16, COOL=32.
  - `cpu_pad_soft_rst`=2'b01 for exactly 16 cycles starting 1 cycle after accept.
  - `busy` high for 48 cycles, `rst_cause`=5'b00011.
- **Bad key:** key 1234 → `sw_key_err` pulse, no reset, `rst_cause` unchanged.
- **Simultaneous sources:** `wdt_timeout`, `had_core_req` and SW core request in the same cycle.
  - Result: `cpu_pad_soft_rst`=2'b10 and `rst_cause[3]`=1. The SW request is consumed.
  - After cooldown, with `had_core_req` still high, a DBG core reset follows.
- **Sys cooldown gating:** SW sys request with `sys_resetn` held low until 100 cycles after accept.
  - `busy` stays high until 2 cycles after the rise, then IDLE.
- **Mid-ASSERT reset:** assert `mcu_rst_signal` low during ASSERT → `cpu_pad_soft_rst`=0 immediately, `rst_cause`=5'b00001, simultaneous `cause_clr` does not override set bits.
